// File: rtl/ext_pkg.sv
// Shared definitions for the field-extension pipeline: mode codes,
// field-width select codes and the code-to-width mapping.
package ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZEXT       = 2'd0,
        MODE_SEXT       = 2'd1,
        MODE_ZEXT_LSHF1 = 2'd2,
        MODE_SEXT_LSHF1 = 2'd3
    } mode_e;

    localparam logic [2:0] SEL_W5  = 3'd0;
    localparam logic [2:0] SEL_W6  = 3'd1;
    localparam logic [2:0] SEL_W8  = 3'd2;
    localparam logic [2:0] SEL_W9  = 3'd3;
    localparam logic [2:0] SEL_W11 = 3'd4;

    // Width in bits selected by a field_sel code; 0 marks an illegal code.
    function automatic logic [3:0] sel_to_width(input logic [2:0] sel);
        logic [3:0] width;
        case (sel)
            SEL_W5:  width = 4'd5;
            SEL_W6:  width = 4'd6;
            SEL_W8:  width = 4'd8;
            SEL_W9:  width = 4'd9;
            SEL_W11: width = 4'd11;
            default: width = 4'd0;
        endcase
        return width;
    endfunction

    function automatic logic mode_is_signed(input mode_e mode);
        return (mode == MODE_SEXT) || (mode == MODE_SEXT_LSHF1);
    endfunction

    function automatic logic mode_is_shift(input mode_e mode);
        return (mode == MODE_ZEXT_LSHF1) || (mode == MODE_SEXT_LSHF1);
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extend/shift datapath. Takes the raw field bus, the field
// width and the mode; bits of f at or above w are ignored. An illegal width
// (zero, wider than the bus, or not narrower than the result) forces a zero
// result with err set.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  f,
    input  logic [3:0]       w,
    input  mode_e            mode,
    output logic [OUT_W-1:0] value,
    output logic             err
);

    logic [31:0]      w32;
    logic             sign_bit;
    logic             fill_bit;
    logic [OUT_W-1:0] ext_value;
    logic [OUT_W-1:0] shifted;

    assign w32 = {28'd0, w};

    // Pick the field's top bit f[w-1] without a variable-range part select.
    always_comb begin
        sign_bit = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (w32 == 32'(i + 1)) begin
                sign_bit = f[i];
            end
        end
    end

    assign fill_bit = mode_is_signed(mode) & sign_bit;

    // Bits below w come from the field; everything above is the fill bit.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext
        if (gi < IN_W) begin : g_field
            assign ext_value[gi] = (w32 > 32'(gi)) ? f[gi] : fill_bit;
        end else begin : g_fill
            assign ext_value[gi] = fill_bit;
        end
    end

    assign shifted = {ext_value[OUT_W-2:0], 1'b0};

    assign err   = (w == 4'd0) || (w32 > 32'(IN_W)) || (w32 >= 32'(OUT_W));
    assign value = err ? '0 : (mode_is_shift(mode) ? shifted : ext_value);

endmodule

// File: rtl/ext_pipe.sv
// Two-stage valid/ready pipeline around ext_core. S1 registers the raw
// request, S2 registers the computed result. in_ready looks one stage ahead
// so a full pipe keeps streaming while the consumer drains.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [2:0]       field_sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic             s1_valid_reg;
    logic [IN_W-1:0]  s1_data_reg;
    logic [2:0]       s1_sel_reg;
    mode_e            s1_mode_reg;

    logic             s2_valid_reg;
    logic [OUT_W-1:0] s2_data_reg;
    logic             s2_err_reg;

    logic             s2_open;
    logic             in_accept;
    logic [OUT_W-1:0] core_value;
    logic             core_err;

    // S2 can take a new entry when empty or when its entry leaves this cycle.
    assign s2_open   = !s2_valid_reg || out_ready;
    assign in_ready  = !s1_valid_reg || s2_open;
    assign in_accept = in_valid && in_ready;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .f     (s1_data_reg),
        .w     (sel_to_width(s1_sel_reg)),
        .mode  (s1_mode_reg),
        .value (core_value),
        .err   (core_err)
    );

    // S1: capture a new request, or empty out once it has moved into S2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_sel_reg   <= '0;
            s1_mode_reg  <= MODE_ZEXT;
        end else if (in_accept) begin
            s1_valid_reg <= 1'b1;
            s1_data_reg  <= in_data;
            s1_sel_reg   <= field_sel;
            s1_mode_reg  <= mode_e'(mode);
        end else if (s2_open) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S2: load the computed result whenever it is free; hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_err_reg   <= 1'b0;
        end else if (s2_open) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= core_value;
                s2_err_reg  <= core_err;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_err   = s2_err_reg;

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 11, raw input field bus width in bits (legal 5..OUT_W-1).
REQ-002 Parameter OUT_W, default 16, extended result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents a transaction.
REQ-006 in_ready  output  1  block accepts the transaction this cycle.
REQ-007 in_data  input  IN_W  raw field; only the LSBs selected by field_sel are used.
REQ-008 field_sel  input  3  field width code: 0=5, 1=6, 2=8, 3=9, 4=11 bits; 5..7 illegal.
REQ-009 mode  input  2  0=ZEXT, 1=SEXT, 2=ZEXT_LSHF1, 3=SEXT_LSHF1.
REQ-010 out_valid  output  1  result presented downstream.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_data  output  OUT_W  extended (and optionally shifted) result.
REQ-013 out_err  output  1  result is from an illegal request; qualified by out_valid.

Function
REQ-014 Transfer occurs on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-015 Two registered stages: S1 captures in_data/field_sel/mode; S2 holds computed out_data/out_err.
REQ-016 Latency from input transfer to out_valid SHALL be exactly 2 cycles with no stall.
REQ-017 Throughput SHALL be one transaction per cycle while out_ready stays high.
REQ-018 in_ready = !S1_valid || !S2_valid || out_ready; S1 advances into S2 when S2 empty or draining same cycle.
REQ-019 out_valid and out_data/out_err SHALL stay stable while out_valid && !out_ready.
REQ-020 Simultaneous output drain and input accept in same cycle SHALL lose and duplicate no transaction; order preserved.
REQ-021 Field value f = in_data[w-1:0], w from field_sel; in_data bits above w SHALL be ignored.
REQ-022 ZEXT: upper OUT_W-w bits zero; SEXT: upper bits replicate f[w-1].
REQ-023 LSHF1 modes: extended value shifted left 1, LSB zero, MSB discarded (result OUT_W bits).
REQ-024 Illegal field_sel, or w > IN_W, or w >= OUT_W: out_data = 0, out_err = 1; otherwise out_err = 0.
REQ-025 Illegal requests SHALL still occupy a pipeline slot and obey the handshake.

Reset
REQ-026 While reset high: S1/S2 valid = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
REQ-027 Reset asserted mid-transaction SHALL discard all in-flight transactions immediately, no output produced.
REQ-028 First transfer possible on the first rising clk edge after reset deasserts.

Structure
REQ-029 Shared package ext_pkg SHALL hold mode codes, field_sel codes and the code-to-width function.
REQ-030 Combinational extend/shift logic SHALL be one sub-module ext_core (inputs f, w, mode; outputs value, err), instantiated once between S1 and S2.
REQ-031 No latches; all registers reset asynchronously.

Verification
REQ-032 ZEXT, sel=2, in_data=0x0F6, out_ready=1 -> out_data=0x00F6, out_err=0, two cycles after accept.
REQ-033 SEXT_LSHF1, sel=3, in_data=0x1FF -> 0xFFFE; SEXT, sel=0, in_data=0x7F0 (f=0x10) -> 0xFFF0.
REQ-034 Back-to-back 8 SEXT sel=1 inputs 0x00..0x3F step 9, out_ready=1 -> 8 results in order, one per cycle, no bubbles.
REQ-035 out_ready=0 for 5 cycles with continuous in_valid -> in_ready falls after 2 accepts, out_data held constant, all results delivered in order after out_ready=1.
REQ-036 field_sel=6 -> out_data=0x0000, out_err=1, next legal request unaffected.
REQ-037 reset pulsed with 2 transactions in flight -> out_valid=0 within the reset cycle, no stale output after release.
